// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 scan-code constants, direction encoding and decoder state encoding
// for the key scheduler and its direction queue.
package ps2_keys_pkg;

    localparam int unsigned DIR_W = 2;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_START   = 8'h1B;
    localparam logic [7:0] SC_PAUSE   = 8'h4D;
    localparam logic [7:0] SC_RESTART = 8'h2D;
    localparam logic [7:0] SC_ESC     = 8'h76;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Opposite directions differ only in bit 1 of the encoding.
    function automatic logic is_reverse(input logic [DIR_W-1:0] a, input logic [DIR_W-1:0] b);
        return a == (b ^ 2'd2);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// DEPTH x 2-bit synchronous FIFO holding pending direction changes.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module dir_fifo
    import ps2_keys_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DIR_W-1:0]         push_data_i,
    output logic [DIR_W-1:0]         head_o,
    output logic [DIR_W-1:0]         tail_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DIR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    always_comb begin
        empty_o  = (cnt_q == '0);
        full_o   = (cnt_q == CW'(DEPTH));
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge CLK) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign tail_o  = mem_q[wr_ptr_q - AW'(1)];
    assign count_o = cnt_q;

endmodule

// File: rtl/ps2_key_scheduler.sv
// PS/2 scan-code decoder feeding a per-tick direction queue and command pulses
// for the snake game core.
module ps2_key_scheduler
    import ps2_keys_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter logic [1:0]  INIT_DIR       = 2'd1,
    parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [7:0]             RX_DATA,
    input  logic                   RX_VALID,
    input  logic                   TICK,
    output logic [1:0]             DIR_OUT,
    output logic                   DIR_VALID,
    output logic                   CMD_START,
    output logic                   CMD_PAUSE,
    output logic                   CMD_RESTART,
    output logic                   CMD_ESC,
    output logic [$clog2(DEPTH):0] Q_COUNT,
    output logic                   OVERFLOW
);

    dec_state_e  state_q, state_d;
    logic [15:0] tmo_q, tmo_d;

    logic             make_c, is_arrow_c;
    logic [DIR_W-1:0] key_dir_c, ref_dir_c;
    logic             start_c, pause_c, restart_c, esc_c;
    logic             push_c, pop_c;

    logic [DIR_W-1:0] dir_q, dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic             ovf_q, ovf_d;
    logic             start_q, pause_q, restart_q, esc_q;

    logic [DIR_W-1:0] fifo_head, fifo_tail;
    logic             fifo_full, fifo_empty;

    // Decoder state register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Decoder next state; the timeout only runs while a prefix is pending
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        if (RX_VALID) begin
            tmo_d = '0;
            if (RX_DATA == SC_EXT) begin
                state_d = ST_EXT;
            end else begin
                case (state_q)
                    ST_IDLE: if (RX_DATA == SC_BRK) state_d = ST_BRK;
                    ST_EXT:  state_d = (RX_DATA == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == PREFIX_TIMEOUT - 16'd1) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    // Decoder outputs: make-code qualification and key lookup
    always_comb begin
        make_c     = RX_VALID && (RX_DATA != SC_EXT) && (RX_DATA != SC_BRK) &&
                     ((state_q == ST_IDLE) || (state_q == ST_EXT));
        is_arrow_c = 1'b0;
        key_dir_c  = DIR_UP;
        start_c    = 1'b0;
        pause_c    = 1'b0;
        restart_c  = 1'b0;
        esc_c      = 1'b0;
        if (make_c) begin
            case (RX_DATA)
                SC_UP:      begin is_arrow_c = 1'b1; key_dir_c = DIR_UP;    end
                SC_RIGHT:   begin is_arrow_c = 1'b1; key_dir_c = DIR_RIGHT; end
                SC_DOWN:    begin is_arrow_c = 1'b1; key_dir_c = DIR_DOWN;  end
                SC_LEFT:    begin is_arrow_c = 1'b1; key_dir_c = DIR_LEFT;  end
                SC_START:   start_c   = 1'b1;
                SC_PAUSE:   pause_c   = 1'b1;
                SC_RESTART: restart_c = 1'b1;
                SC_ESC:     esc_c     = 1'b1;
                default:    ;
            endcase
        end
    end

    // Compare against the newest pending move so queued turns chain correctly
    always_comb begin
        ref_dir_c = fifo_empty ? dir_q : fifo_tail;
        push_c    = is_arrow_c && (key_dir_c != ref_dir_c) && !is_reverse(key_dir_c, ref_dir_c);
        pop_c     = TICK && !fifo_empty && !restart_c;
        dir_d       = dir_q;
        dir_valid_d = 1'b0;
        ovf_d       = ovf_q;
        if (restart_c) begin
            dir_d = INIT_DIR;
            ovf_d = 1'b0;
        end else begin
            if (pop_c) begin
                dir_d       = fifo_head;
                dir_valid_d = 1'b1;
            end
            if (push_c && fifo_full && !pop_c) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            dir_q       <= INIT_DIR;
            dir_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            restart_q   <= 1'b0;
            esc_q       <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            ovf_q       <= ovf_d;
            start_q     <= start_c;
            pause_q     <= pause_c;
            restart_q   <= restart_c;
            esc_q       <= esc_c;
        end
    end

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_dir_fifo (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .flush_i     (restart_c),
        .push_i      (push_c),
        .pop_i       (pop_c),
        .push_data_i (key_dir_c),
        .head_o      (fifo_head),
        .tail_o      (fifo_tail),
        .count_o     (Q_COUNT),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign DIR_OUT     = dir_q;
    assign DIR_VALID   = dir_valid_q;
    assign OVERFLOW    = ovf_q;
    assign CMD_START   = start_q;
    assign CMD_PAUSE   = pause_q;
    assign CMD_RESTART = restart_q;
    assign CMD_ESC     = esc_q;

endmodule
